hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the load-use interlock.
- Keeps a per-register scoreboard of results that cannot yet be bypassed:
  - loads, via a countdown of LOAD_USE_CYCLES;
  - multdiv, via a busy/done handshake with a variable-latency unit.
- Produces the FD-stage stall, a stall cause, and multdiv start/kill strobes.
- Sits between the FD latch and the DX latch. It is the pipeline's single source of hazard stalls.

Parameters:
- NUM_REGS, 32, architectural register count; register 0 is hardwired zero and never scoreboarded.
- ADDR_W, 5, register index width; NUM_REGS <= 2**ADDR_W.
- LOAD_USE_CYCLES, 1, stall cycles for an instruction consuming a load result directly behind the load. Range 1..7.
- CNT_W, 3, countdown width; must hold LOAD_USE_CYCLES.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- fd_insn  in  32  instruction in FD
- fd_valid  in  1  FD holds a real instruction (not a bubble)
- issue  in  1  FD instruction moves into DX at this edge
- flush  in  1  branch/jump taken; kills both the DX and FD instructions at this edge
- md_done  in  1  multdiv result written back this cycle
- stall  out  1  hold PC/FD and insert a bubble into DX
- stall_cause  out  2  00 none, 01 load-use, 10 multdiv RAW/WAW, 11 multdiv structural
- md_start  out  1  start the multdiv unit (= issue & FD is multdiv & ~flush)
- md_kill  out  1  abort the in-flight multdiv (flush while the DX instruction is the multdiv just started)
- md_busy  out  1  multdiv in flight

Behaviour:
- Instruction fields:
  - opcode [31:27], rd [26:22], rs [21:17], rt [16:12].
  - A multdiv is opcode 00000 with ALU op [6:2] of 00110 or 00111.
- Sources per instruction class:
  - R-type: rs, rt.
  - I-type ALU/lw: rs.
  - sw (00111): rs, plus rd as store data.
  - bne/blt (00010/00110): rd, rs.
  - jr (00100): rd.
  - Others: none.
- Destinations: R-type, addi, lw, and jal (which writes r31).
- Source register 0 never matches anything.
- Scoreboard state: cnt[r] (CNT_W bits) per register; md_busy; md_rd; a last-issue record (rd, is_load, is_md, valid) describing the current DX instruction.
- Issue of a lw with rd != 0 and no flush: cnt[rd] <= LOAD_USE_CYCLES at the edge.
  - Every other cycle, any cnt > 0 decrements by 1, independent of stall.
  - Issue takes priority over decrement for the same register.
- Issue of a multdiv: md_busy <= 1 and md_rd <= rd.
  - md_done clears md_busy.
  - md_done and a new multdiv issue in the same cycle leave md_busy = 1 with the new md_rd.
- Stall is combinational; it is forced to 0 when reset = 1 or fd_valid = 0. Conditions, with cause priority 11 > 10 > 01:
  - 01 load-use: any FD source r has cnt[r] > 0.
    - Exception: the sw store-data operand (rd) is exempt, because it is bypassed M->W.
  - 10 multdiv RAW/WAW: md_busy & ~md_done, and an FD source or FD destination equals md_rd.
    - No exemption for sw store data.
  - 11 structural: FD is a multdiv & md_busy & ~md_done.
- Latency with LOAD_USE_CYCLES = 1: a load issued at edge t stalls a dependent FD instruction for exactly the cycle after t. The dependent issues at the next edge.
- Flush:
  - If the last-issue record is valid, its effect is undone at the edge:
    - a load clears cnt[rd];
    - a multdiv clears md_busy and pulses md_kill in that cycle.
  - issue is ignored in a flush cycle; FD is killed too.
  - md_done in a flush cycle still clears md_busy.
- The last-issue record is set on issue and cleared on any non-issue edge, because a bubble enters DX.
- Reset: all cnt = 0, md_busy = 0, md_rd = 0, record invalid. All outputs are 0 in the reset cycle and the cycle after.
- Reset mid-operation discards pending hazards. The pipeline is flushed by the same reset.

Decomposition:
- Shared package holds:
  - opcode constants (R, ADDI, SW, LW, BNE, BLT, JR, JAL);
  - ALU op constants MUL and DIV;
  - field bit positions;
  - the stall_cause encoding.
- One sub-module, insn_reg_usage. It is purely combinational: insn -> src_a/src_b with valid bits, dst with valid bit, is_load, is_md, is_sw.

Test Plan:
- lw r3 issued, then add r4,r3,r5 in FD -> stall = 1, cause = 01 for exactly 1 cycle; issue on the following edge.
- LOAD_USE_CYCLES = 3, lw r7 then sub r1,r7,r2 -> stall high for 3 consecutive cycles, then 0.
- lw r3 then sw r3,0(r9) -> no stall. Then lw r9 followed by sw r3,0(r9) -> 1 stall cycle, cause 01.
- mul r5 issued (md_start = 1); add r6,r5,r1 in FD -> stall, cause 10, until md_done. Stall drops in the md_done cycle.
- mul in flight, div in FD -> cause 11. md_done and the div issue in the same cycle -> md_busy stays 1 with md_rd = the div's rd.
- mul issued, flush next cycle -> md_kill = 1, md_busy = 0. Reset asserted with cnt[4] = 1 -> stall = 0 and the register is clear afterwards.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared ISA field layout, opcode constants and stall-cause encoding for the
// hazard scoreboard and its instruction decoder.
package hazard_scoreboard_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_JAL  = 5'b00011;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int ALU_HI = 6;
  localparam int ALU_LO = 2;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_LOAD_USE  = 2'b01,
    CAUSE_MD_HAZ    = 2'b10,
    CAUSE_MD_STRUCT = 2'b11
  } stall_cause_e;

  function automatic logic is_multdiv(input logic [31:0] insn);
    return (insn[OP_HI:OP_LO] == OP_R) &&
           ((insn[ALU_HI:ALU_LO] == ALU_MUL) || (insn[ALU_HI:ALU_LO] == ALU_DIV));
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// FD/DX hazard interface: pipeline-side inputs and the scoreboard's stall and
// multdiv control outputs.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic [31:0]  fd_insn;
  logic         fd_valid;
  logic         issue;
  logic         flush;
  logic         md_done;
  logic         stall;
  stall_cause_e stall_cause;
  logic         md_start;
  logic         md_kill;
  logic         md_busy;

  modport master (
    output fd_insn, fd_valid, issue, flush, md_done,
    input  stall, stall_cause, md_start, md_kill, md_busy
  );

  modport slave (
    input  fd_insn, fd_valid, issue, flush, md_done,
    output stall, stall_cause, md_start, md_kill, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard_insn_reg_usage.sv
// Combinational decode of which registers an instruction reads and writes,
// plus the class flags the scoreboard cares about.
module insn_reg_usage
  import hazard_scoreboard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [31:0]       insn,
  output logic [ADDR_W-1:0] src_a,
  output logic              src_a_vld,
  output logic [ADDR_W-1:0] src_b,
  output logic              src_b_vld,
  output logic [ADDR_W-1:0] dst,
  output logic              dst_vld,
  output logic              is_load,
  output logic              is_md,
  output logic              is_sw
);

  logic [4:0]        op;
  logic [ADDR_W-1:0] rd, rs, rt;
  logic              unused_bits;

  assign op          = insn[OP_HI:OP_LO];
  assign rd          = ADDR_W'(insn[RD_HI:RD_LO]);
  assign rs          = ADDR_W'(insn[RS_HI:RS_LO]);
  assign rt          = ADDR_W'(insn[RT_HI:RT_LO]);
  assign unused_bits = ^{insn[11:7], insn[1:0]};

  always_comb begin
    src_a     = '0;
    src_a_vld = 1'b0;
    src_b     = '0;
    src_b_vld = 1'b0;
    dst       = rd;
    dst_vld   = 1'b0;
    is_load   = (op == OP_LW);
    is_sw     = (op == OP_SW);
    is_md     = is_multdiv(insn);
    case (op)
      OP_R:           begin src_a = rs; src_a_vld = 1'b1; src_b = rt; src_b_vld = 1'b1; dst_vld = 1'b1; end
      OP_ADDI, OP_LW: begin src_a = rs; src_a_vld = 1'b1; dst_vld = 1'b1; end
      // store data sits in src_b so the load-use exemption can target it alone
      OP_SW:          begin src_a = rs; src_a_vld = 1'b1; src_b = rd; src_b_vld = 1'b1; end
      OP_BNE, OP_BLT: begin src_a = rd; src_a_vld = 1'b1; src_b = rs; src_b_vld = 1'b1; end
      OP_JR:          begin src_a = rd; src_a_vld = 1'b1; end
      OP_JAL:         begin dst = ADDR_W'(5'd31); dst_vld = 1'b1; end
      default: ;
    endcase
    // r0 is never a real dependency in either direction
    if (src_a == '0) src_a_vld = 1'b0;
    if (src_b == '0) src_b_vld = 1'b0;
    if (dst == '0)   dst_vld   = 1'b0;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard between FD and DX: load-use countdowns, a
// single in-flight multdiv tracker, and the resulting FD stall.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int ADDR_W          = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 3
) (
  input  logic              clock,
  input  logic              reset,
  hazard_scoreboard_if.slave hif
);

  typedef struct packed {
    logic              vld;
    logic              is_load;
    logic              is_md;
    logic [ADDR_W-1:0] rd;
  } rec_t;

  logic [ADDR_W-1:0] src_a, src_b, dst;
  logic              src_a_vld, src_b_vld, dst_vld, is_load, is_md, is_sw;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                           md_busy_q, md_busy_d;
  logic [ADDR_W-1:0]              md_rd_q, md_rd_d;
  rec_t                           rec_q, rec_d;
  logic                           after_rst_q, after_rst_d;

  logic         hold, issue_eff, undo, md_pend, lu_hit, md_hit, md_struct;
  stall_cause_e cause;

  insn_reg_usage #(.ADDR_W(ADDR_W)) u_usage (
    .insn      (hif.fd_insn),
    .src_a     (src_a),
    .src_a_vld (src_a_vld),
    .src_b     (src_b),
    .src_b_vld (src_b_vld),
    .dst       (dst),
    .dst_vld   (dst_vld),
    .is_load   (is_load),
    .is_md     (is_md),
    .is_sw     (is_sw)
  );

  function automatic logic cnt_nz(input logic [ADDR_W-1:0] idx);
    return (32'(idx) < NUM_REGS) && (cnt_q[idx] != '0);
  endfunction

  // outputs stay quiet through the reset cycle and the one after it
  assign hold      = reset | after_rst_q;
  assign issue_eff = hif.issue & ~hif.flush & ~after_rst_q;
  assign undo      = hif.flush & rec_q.vld;

  always_comb begin
    cnt_d = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
      if (undo && rec_q.is_load && rec_q.rd == ADDR_W'(r))
        cnt_d[r] = '0;
      if (issue_eff && is_load && dst_vld && dst == ADDR_W'(r))
        cnt_d[r] = CNT_W'(LOAD_USE_CYCLES);
    end
  end

  always_comb begin
    md_busy_d = md_busy_q;
    md_rd_d   = md_rd_q;
    if (hif.md_done)         md_busy_d = 1'b0;
    if (undo && rec_q.is_md) md_busy_d = 1'b0;
    if (issue_eff && is_md) begin
      md_busy_d = 1'b1;
      md_rd_d   = dst;
    end
    // a bubble enters DX on every edge that does not issue
    rec_d.vld     = issue_eff;
    rec_d.is_load = is_load;
    rec_d.is_md   = is_md;
    rec_d.rd      = dst;
    after_rst_d   = 1'b0;
  end

  always_comb begin
    md_pend   = md_busy_q & ~hif.md_done;
    lu_hit    = (src_a_vld & cnt_nz(src_a)) | (src_b_vld & ~is_sw & cnt_nz(src_b));
    md_hit    = md_pend & ((src_a_vld & (src_a == md_rd_q)) |
                           (src_b_vld & (src_b == md_rd_q)) |
                           (dst_vld   & (dst   == md_rd_q)));
    md_struct = md_pend & is_md;
    cause = CAUSE_NONE;
    if (md_struct)   cause = CAUSE_MD_STRUCT;
    else if (md_hit) cause = CAUSE_MD_HAZ;
    else if (lu_hit) cause = CAUSE_LOAD_USE;
    if (hold || !hif.fd_valid) cause = CAUSE_NONE;
  end

  always_comb begin
    hif.stall       = (cause != CAUSE_NONE);
    hif.stall_cause = cause;
    hif.md_start    = issue_eff & is_md & ~hold;
    hif.md_kill     = undo & rec_q.is_md & ~hold;
    hif.md_busy     = md_busy_q & ~hold;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      md_busy_q   <= 1'b0;
      md_rd_q     <= '0;
      rec_q       <= '0;
      after_rst_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      md_busy_q   <= md_busy_d;
      md_rd_q     <= md_rd_d;
      rec_q       <= rec_d;
      after_rst_q <= after_rst_d;
    end
  end

endmodule
